// File: rtl/mod12_pkg.sv
// Shared types and the mod-12 counter rule used by the checker and its predictor.
package mod12_pkg;

    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_MODULUS = 12;

    typedef logic [DEF_WIDTH-1:0] count_t;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } chk_state_e;

    localparam count_t DEF_LAST = count_t'(DEF_MODULUS - 1);

    // Load has priority; otherwise count up or down with wrap at the modulus.
    function automatic count_t next_count(
        input count_t q,
        input logic   load,
        input logic   mode,
        input count_t din,
        input count_t last = DEF_LAST
    );
        count_t r;
        if (load) begin
            r = din;
        end else if (mode) begin
            r = (q == last) ? '0 : q + count_t'(1);
        end else begin
            r = (q == '0) ? last : q - count_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/mod12_ref_model.sv
// Registered next-count predictor with wrap decode; advances only when i_adv is high.
module mod12_ref_model
    import mod12_pkg::*;
#(
    parameter int unsigned MODULUS = DEF_MODULUS
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_adv,
    input  count_t i_base,
    input  logic   i_load,
    input  logic   i_mode,
    input  count_t i_din,
    output count_t o_exp,
    output logic   o_wrap_up,
    output logic   o_wrap_dn
);

    localparam count_t LAST = count_t'(MODULUS - 1);

    count_t r_exp;
    logic   r_wrap_up;
    logic   r_wrap_dn;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_exp     <= '0;
            r_wrap_up <= 1'b0;
            r_wrap_dn <= 1'b0;
        end else begin
            // Wrap pulses travel with the prediction they describe.
            r_wrap_up <= i_adv && !i_load &&  i_mode && (i_base == LAST);
            r_wrap_dn <= i_adv && !i_load && !i_mode && (i_base == '0);
            if (i_adv) begin
                r_exp <= next_count(i_base, i_load, i_mode, i_din, LAST);
            end
        end
    end

    assign o_exp     = r_exp;
    assign o_wrap_up = r_wrap_up;
    assign o_wrap_dn = r_wrap_dn;

endmodule

// File: rtl/mod12_count_checker.sv
// Snooping checker for the mod-12 up/down counter: SYNC/TRACK/FAULT tracking, error stats.
// Optional load/wrap coverage counters enabled by `define MOD12_CHK_COVERAGE_EN.
module mod12_count_checker
    import mod12_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MODULUS   = DEF_MODULUS,
    parameter int unsigned ERR_CNT_W = 8,
    parameter bit          RESYNC    = 1'b1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     datain,
    input  logic                 load,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     dataout,
    output logic [WIDTH-1:0]     exp_count,
    output logic                 synced,
    output logic                 err,
    output logic                 illegal,
    output logic                 fault,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 wrap_up,
    output logic                 wrap_dn,
    output logic [15:0]          load_cnt,
    output logic [15:0]          wrap_cnt
);

    chk_state_e           r_state;
    logic                 r_err;
    logic                 r_illegal;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    count_t w_exp;
    logic   w_wrap_up;
    logic   w_wrap_dn;
    logic   w_din_legal;
    logic   w_bad_load;
    logic   w_bad_out;
    logic   w_mismatch;
    logic   w_err;
    logic   w_adv;

    assign w_din_legal = 32'(datain) < MODULUS;
    assign w_bad_load  = load && !w_din_legal;
    assign w_bad_out   = 32'(dataout) >= MODULUS;
    assign w_mismatch  = !w_bad_out && (dataout != w_exp);
    assign w_err       = w_bad_out || w_mismatch;

    // Prediction always rebases on dataout: equal to exp_count when matching, the adopted value otherwise.
    assign w_adv = ((r_state == SYNC)  && !w_bad_load) ||
                   ((r_state == TRACK) && !w_bad_out && !w_bad_load && !(w_mismatch && !RESYNC));

    mod12_ref_model #(
        .MODULUS (MODULUS)
    ) u_ref (
        .i_clk     (clock),
        .i_rst     (rst),
        .i_adv     (w_adv),
        .i_base    (dataout),
        .i_load    (load),
        .i_mode    (mode),
        .i_din     (datain),
        .o_exp     (w_exp),
        .o_wrap_up (w_wrap_up),
        .o_wrap_dn (w_wrap_dn)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state   <= SYNC;
            r_err     <= 1'b0;
            r_illegal <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err     <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                SYNC: begin
                    r_illegal <= w_bad_load;
                    if (!w_bad_load) begin
                        r_state <= TRACK;
                    end
                end
                TRACK: begin
                    r_err     <= w_err;
                    r_illegal <= w_bad_out || w_bad_load;
                    if (w_err && (r_err_cnt != '1)) begin
                        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                    end
                    // An illegal value makes the next sample untrustworthy, so re-adopt instead.
                    if (w_mismatch && !RESYNC) begin
                        r_state <= FAULT;
                    end else if (w_bad_out || w_bad_load) begin
                        r_state <= SYNC;
                    end
                end
                FAULT: begin
                    r_state <= FAULT;
                end
                default: begin
                    r_state <= SYNC;
                end
            endcase
        end
    end

    assign exp_count = w_exp;
    assign synced    = (r_state == TRACK);
    assign fault     = (r_state == FAULT);
    assign err       = r_err;
    assign illegal   = r_illegal;
    assign err_cnt   = r_err_cnt;
    assign wrap_up   = w_wrap_up;
    assign wrap_dn   = w_wrap_dn;

`ifdef MOD12_CHK_COVERAGE_EN
    logic [15:0] r_load_cnt;
    logic [15:0] r_wrap_cnt;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_load_cnt <= '0;
            r_wrap_cnt <= '0;
        end else begin
            if (load && w_din_legal && (r_load_cnt != '1)) begin
                r_load_cnt <= r_load_cnt + 16'd1;
            end
            if ((w_wrap_up || w_wrap_dn) && (r_wrap_cnt != '1)) begin
                r_wrap_cnt <= r_wrap_cnt + 16'd1;
            end
        end
    end

    assign load_cnt = r_load_cnt;
    assign wrap_cnt = r_wrap_cnt;
`else
    assign load_cnt = '0;
    assign wrap_cnt = '0;
`endif

endmodule

// File: tb/tb_mod12_count_checker.sv
// Self-checking bench: two checkers (RESYNC=1 and RESYNC=0) watch a behavioural counter.
module tb_mod12_count_checker;

    localparam int unsigned M = 12;

    logic        clock = 1'b0;
    logic        rst;
    logic        load;
    logic        mode;
    logic [3:0]  datain;
    logic [3:0]  dataout;

    logic [3:0]  exp_o   [2];
    logic        synced_o[2];
    logic        err_o   [2];
    logic        ill_o   [2];
    logic        fault_o [2];
    logic [7:0]  ecnt_o  [2];
    logic        wu_o    [2];
    logic        wd_o    [2];
    logic [15:0] lcnt_o  [2];
    logic [15:0] wcnt_o  [2];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned wu_seen;
    int unsigned wd_seen;

    logic [3:0]  cnt;

    // Reference model: 0 = adopting, 1 = tracking, 2 = faulted.
    int          m_st  [2];
    logic [3:0]  m_exp [2];
    bit          m_err [2];
    bit          m_ill [2];
    bit          m_wu  [2];
    bit          m_wd  [2];
    int unsigned m_ecnt[2];
    int unsigned m_lcnt[2];
    int unsigned m_wcnt[2];

    always #5 clock = ~clock;

    mod12_count_checker #(
        .WIDTH     (4),
        .MODULUS   (12),
        .ERR_CNT_W (8),
        .RESYNC    (1'b1)
    ) u_dut_rs (
        .clock     (clock),
        .rst       (rst),
        .datain    (datain),
        .load      (load),
        .mode      (mode),
        .dataout   (dataout),
        .exp_count (exp_o[0]),
        .synced    (synced_o[0]),
        .err       (err_o[0]),
        .illegal   (ill_o[0]),
        .fault     (fault_o[0]),
        .err_cnt   (ecnt_o[0]),
        .wrap_up   (wu_o[0]),
        .wrap_dn   (wd_o[0]),
        .load_cnt  (lcnt_o[0]),
        .wrap_cnt  (wcnt_o[0])
    );

    mod12_count_checker #(
        .WIDTH     (4),
        .MODULUS   (12),
        .ERR_CNT_W (8),
        .RESYNC    (1'b0)
    ) u_dut_ft (
        .clock     (clock),
        .rst       (rst),
        .datain    (datain),
        .load      (load),
        .mode      (mode),
        .dataout   (dataout),
        .exp_count (exp_o[1]),
        .synced    (synced_o[1]),
        .err       (err_o[1]),
        .illegal   (ill_o[1]),
        .fault     (fault_o[1]),
        .err_cnt   (ecnt_o[1]),
        .wrap_up   (wu_o[1]),
        .wrap_dn   (wd_o[1]),
        .load_cnt  (lcnt_o[1]),
        .wrap_cnt  (wcnt_o[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Counter behaviour: 4-bit register, load first, then up/down with wrap at 11/0.
    function automatic logic [3:0] cnt_next(logic [3:0] q, bit ld, bit md, logic [3:0] din);
        if (ld) return din;
        if (md) return (q == 4'(M - 1)) ? 4'd0 : 4'(q + 4'd1);
        return (q == 4'd0) ? 4'(M - 1) : 4'(q - 4'd1);
    endfunction

    task automatic model_step(input int k, input bit r, input bit ld, input bit md,
                              input logic [3:0] din, input logic [3:0] dout);
        bit bad_load;
        bit bad_out;
        bit mis;
        bit predict;
        if (r) begin
            m_st[k] = 0; m_exp[k] = 0; m_err[k] = 0; m_ill[k] = 0;
            m_wu[k] = 0; m_wd[k] = 0; m_ecnt[k] = 0; m_lcnt[k] = 0; m_wcnt[k] = 0;
            return;
        end
        if (m_wu[k] || m_wd[k]) m_wcnt[k] = (m_wcnt[k] == 65535) ? 65535 : m_wcnt[k] + 1;
        if (ld && din < M)      m_lcnt[k] = (m_lcnt[k] == 65535) ? 65535 : m_lcnt[k] + 1;
        bad_load = ld && (din >= M);
        bad_out  = (dout >= M);
        predict  = 0;
        m_err[k] = 0; m_ill[k] = 0; m_wu[k] = 0; m_wd[k] = 0;
        if (m_st[k] == 0) begin
            m_ill[k] = bad_load;
            if (!bad_load) begin
                predict = 1;
                m_st[k] = 1;
            end
        end else if (m_st[k] == 1) begin
            mis = !bad_out && (dout != m_exp[k]);
            if (bad_out || mis) begin
                m_err[k]  = 1;
                m_ecnt[k] = (m_ecnt[k] == 255) ? 255 : m_ecnt[k] + 1;
            end
            m_ill[k] = bad_out || bad_load;
            if (mis && k == 1)           m_st[k] = 2;
            else if (bad_out || bad_load) m_st[k] = 0;
            else                          predict = 1;
        end
        if (predict) begin
            m_exp[k] = cnt_next(dout, ld, md, din);
            m_wu[k]  = !ld &&  md && (dout == M - 1);
            m_wd[k]  = !ld && !md && (dout == 0);
        end
    endtask

    task automatic compare_outputs();
        string pfx;
        for (int k = 0; k < 2; k++) begin
            pfx = (k == 0) ? "rs" : "ft";
            check({pfx, ".exp_count"}, exp_o[k],    m_exp[k]);
            check({pfx, ".synced"},    synced_o[k], m_st[k] == 1);
            check({pfx, ".fault"},     fault_o[k],  m_st[k] == 2);
            check({pfx, ".err"},       err_o[k],    m_err[k]);
            check({pfx, ".illegal"},   ill_o[k],    m_ill[k]);
            check({pfx, ".err_cnt"},   ecnt_o[k],   m_ecnt[k]);
            check({pfx, ".wrap_up"},   wu_o[k],     m_wu[k]);
            check({pfx, ".wrap_dn"},   wd_o[k],     m_wd[k]);
`ifdef MOD12_CHK_COVERAGE_EN
            check({pfx, ".load_cnt"},  lcnt_o[k],   m_lcnt[k]);
            check({pfx, ".wrap_cnt"},  wcnt_o[k],   m_wcnt[k]);
`else
            check({pfx, ".load_cnt"},  lcnt_o[k],   0);
            check({pfx, ".wrap_cnt"},  wcnt_o[k],   0);
`endif
        end
    endtask

    // One clock: drive inputs, advance model and counter, then check just after the edge.
    task automatic step(input bit r, input bit ld, input bit md, input logic [3:0] din);
        rst     = r;
        load    = ld;
        mode    = md;
        datain  = din;
        dataout = cnt;
        model_step(0, r, ld, md, din, cnt);
        model_step(1, r, ld, md, din, cnt);
        cnt = r ? 4'd0 : cnt_next(cnt, ld, md, din);
        @(posedge clock);
        #1;
        compare_outputs();
        wu_seen += wu_o[0];
        wd_seen += wd_o[0];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         r, ld, md;
        logic [3:0] din;
        cnt = 4'd0;
        wu_seen = 0;
        wd_seen = 0;

        step(1, 0, 0, 4'd0);
        step(1, 0, 0, 4'd0);
        check("reset.exp_count", exp_o[0], 0);
        check("reset.synced", synced_o[0], 0);

        // Up wrap from 0 through 11 and around.
        wu_seen = 0; wd_seen = 0;
        repeat (14) step(0, 0, 1, 4'd0);
        check("upwrap.wrap_up_count", wu_seen, 1);
        check("upwrap.wrap_dn_count", wd_seen, 0);
        check("upwrap.err_cnt", ecnt_o[0], 0);

        // Load 2 then count down 2,1,0,11.
        wu_seen = 0; wd_seen = 0;
        step(0, 1, 0, 4'd2);
        repeat (4) step(0, 0, 0, 4'd0);
        check("dnwrap.wrap_dn_count", wd_seen, 1);
        check("dnwrap.exp_count", exp_o[0], 10);
        check("dnwrap.err_cnt", ecnt_o[0], 0);

        // Load beats a down-count from 0, and no wrap is predicted.
        step(0, 1, 0, 4'd0);
        wu_seen = 0; wd_seen = 0;
        step(0, 1, 0, 4'd7);
        check("loadprio.exp_count", exp_o[0], 7);
        check("loadprio.wrap_dn_count", wd_seen, 0);
        step(0, 0, 1, 4'd0);
        check("loadprio.err", err_o[0], 0);

        // Dataout 5 while 3 is expected.
        step(0, 1, 1, 4'd2);
        step(0, 0, 1, 4'd0);
        cnt = 4'd5;
        step(0, 0, 1, 4'd0);
        check("mismatch.err", err_o[0], 1);
        check("mismatch.err_cnt", ecnt_o[0], 1);
        check("mismatch.next_exp", exp_o[0], 6);
        check("mismatch.fault_nores", fault_o[1], 1);
        step(0, 0, 1, 4'd0);
        check("mismatch.err_after", err_o[0], 0);
        check("mismatch.fault_sticky", fault_o[1], 1);

        // Illegal load of 13, follow-on cycle re-adopted.
        step(0, 1, 1, 4'd13);
        check("illload.illegal", ill_o[0], 1);
        check("illload.err", err_o[0], 0);
        step(0, 1, 1, 4'd4);
        check("illload.follow_illegal", ill_o[0], 0);
        step(0, 0, 0, 4'd0);
        check("illload.err_cnt", ecnt_o[0], 1);

        // Two more mismatches, then reset mid-run.
        cnt = 4'd9;
        step(0, 0, 1, 4'd0);
        cnt = 4'd1;
        step(0, 0, 1, 4'd0);
        check("midrst.pre_err_cnt", ecnt_o[0], 3);
        step(1, 0, 1, 4'd0);
        check("midrst.err_cnt", ecnt_o[0], 0);
        check("midrst.fault", fault_o[1], 0);
        check("midrst.synced", synced_o[0], 0);

        // Error counter saturation: a mismatch on every tracked cycle.
        step(0, 0, 1, 4'd0);
        repeat (260) begin
            cnt = 4'((cnt + 5) % M);
            step(0, 0, 1, 4'd0);
        end
        check("sat.err_cnt", ecnt_o[0], 255);
        check("sat.err_cnt_frozen", ecnt_o[1], 1);

        // Randomised traffic with occasional glitches and resets.
        step(1, 0, 0, 4'd0);
        repeat (500) begin
            r   = ($urandom_range(0, 99) == 0);
            ld  = ($urandom_range(0, 5) == 0);
            md  = 1'($urandom_range(0, 1));
            din = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 24) == 0) cnt = 4'($urandom_range(0, 15));
            step(r, ld, md, din);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
